// File: rtl/sq_wave_pkg.sv
// sq_wave_pkg: shared constants, FSM state type and result saturation for sq_wave_meter
package sq_wave_pkg;
  localparam logic [3:0] UNIT_TICK     = 4'd10;
  localparam logic [3:0] ROUND_THRESH  = 4'd5;
  localparam logic [5:0] MAX_UNITS     = 6'd15;
  localparam logic [4:0] TIMEOUT_UNITS = 5'd31;

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  // Returns {err, value}: value clamped to 0..15, err set on zero or clamped results
  function automatic logic [4:0] sat_result(input logic [5:0] raw);
    return raw > MAX_UNITS ? {1'b1, 4'd15} :
           raw == 6'd0     ? {1'b1, 4'd0}  : {1'b0, raw[3:0]};
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer plus rise/fall detection against a delayed copy
// Ports: clk, reset_n (async, active-low), sq_in (async input),
//        level (synchronized sq_in), rise/fall (one-cycle edge strobes)
module sync_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sq_in,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, dly;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) {s1, s2, dly} <= '0;
    else {s1, s2, dly} <= {sq_in, s1, s2};
  assign level = s2;
  assign rise  = s2 & ~dly;
  assign fall  = ~s2 & dly;
endmodule

// File: rtl/sq_wave_meter.sv
// sq_wave_meter: measures high/low times of a square wave in 100 ns units
// Ports: clk (100 MHz), reset_n (async, active-low), sq_in (async square wave),
//        meas_on/meas_off (4-bit results), meas_valid (result strobe),
//        meas_err (zero or saturated phase), timeout (phase too long), busy (measuring)
module sq_wave_meter
  import sq_wave_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sq_in,
  output logic [3:0] meas_on,
  output logic [3:0] meas_off,
  output logic       meas_valid,
  output logic       meas_err,
  output logic       timeout,
  output logic       busy
);
  logic level, rise, fall;
  sync_edge_detect u_sync (.clk(clk), .reset_n(reset_n), .sq_in(sq_in), .level(level), .rise(rise), .fall(fall));

  state_t     state, state_d;
  logic [3:0] prescale, prescale_d, on_res, on_res_d, meas_on_d, meas_off_d;
  logic [4:0] units, units_d, sat;
  logic       on_err, on_err_d, meas_valid_d, meas_err_d, timeout_d, to_hit, edge_ok, wrap;
  logic [5:0] raw;

  assign busy = state != IDLE;

  always_comb begin
    raw    = {1'b0, units} + {5'b0, prescale >= ROUND_THRESH};
    sat    = sat_result(raw);
    to_hit = busy && units == TIMEOUT_UNITS;
    // an edge landing on the timeout cycle is dropped entirely
    edge_ok = (rise | fall) & ~to_hit;
    wrap    = prescale == UNIT_TICK - 4'd1;
    prescale_d   = edge_ok ? 4'd1 : wrap ? 4'd0 : prescale + 4'd1;
    units_d      = edge_ok ? 5'd0 : wrap ? units + 5'd1 : units;
    state_d      = state;
    on_res_d     = on_res;
    on_err_d     = on_err;
    meas_on_d    = meas_on;
    meas_off_d   = meas_off;
    meas_err_d   = meas_err;
    meas_valid_d = 1'b0;
    timeout_d    = 1'b0;
    if (to_hit) begin
      state_d   = IDLE;
      timeout_d = 1'b1;
    end else if (state == IDLE && rise) begin
      state_d = MEAS_HIGH;
    end else if (state == MEAS_HIGH && fall) begin
      state_d  = MEAS_LOW;
      on_res_d = sat[3:0];
      on_err_d = sat[4];
    end else if (state == MEAS_LOW && rise) begin
      state_d      = MEAS_HIGH;
      meas_on_d    = on_res;
      meas_off_d   = sat[3:0];
      meas_err_d   = on_err | sat[4];
      meas_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_d;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prescale   <= '0;
      units      <= '0;
      on_res     <= '0;
      on_err     <= 1'b0;
      meas_on    <= '0;
      meas_off   <= '0;
      meas_err   <= 1'b0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      prescale   <= prescale_d;
      units      <= units_d;
      on_res     <= on_res_d;
      on_err     <= on_err_d;
      meas_on    <= meas_on_d;
      meas_off   <= meas_off_d;
      meas_err   <= meas_err_d;
      meas_valid <= meas_valid_d;
      timeout    <= timeout_d;
    end
endmodule

// File: tb/tb_sq_wave_meter.sv
// tb_sq_wave_meter: scoreboard bench for sq_wave_meter
module tb_sq_wave_meter;
  logic       clk = 1'b0, reset_n = 1'b0, sq_in = 1'b0;
  logic [3:0] meas_on, meas_off;
  logic       meas_valid, meas_err, timeout, busy;

  typedef struct packed {logic [3:0] on; logic [3:0] off; logic err;} exp_t;
  exp_t q[$];
  int pass = 0, total = 0, to_cnt = 0;

  always #5 clk = ~clk;

  sq_wave_meter dut (.clk(clk), .reset_n(reset_n), .sq_in(sq_in), .meas_on(meas_on), .meas_off(meas_off),
                     .meas_valid(meas_valid), .meas_err(meas_err), .timeout(timeout), .busy(busy));

  function automatic logic [4:0] phase_model(input int n);
    int r;
    r = (n + 5) / 10;
    if (r > 15) return {1'b1, 4'd15};
    if (r == 0) return {1'b1, 4'd0};
    return {1'b0, 4'(r)};
  endfunction

  function automatic exp_t model(input int h, input int l);
    logic [4:0] a, b;
    a = phase_model(h);
    b = phase_model(l);
    return exp_t'{on: a[3:0], off: b[3:0], err: a[4] | b[4]};
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (meas_valid) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: on=%0d off=%0d err=%0b with nothing expected", meas_on, meas_off, meas_err);
        end else begin
          e = q.pop_front();
          total++; if (meas_on === e.on) pass++; else $display("FAIL meas_on: got %0d want %0d", meas_on, e.on);
          total++; if (meas_off === e.off) pass++; else $display("FAIL meas_off: got %0d want %0d", meas_off, e.off);
          total++; if (meas_err === e.err) pass++; else $display("FAIL meas_err: got %0b want %0b", meas_err, e.err);
        end
      end
      if (timeout) begin
        to_cnt++;
        total++; if (busy === 1'b0) pass++; else $display("FAIL busy_at_timeout: got %0b want 0", busy);
      end
    end
  endtask

  task automatic drive(input logic v, input int n);
    sq_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic period(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
    q.push_back(model(h, l));
  endtask

  task automatic check_drain();
    total++;
    if (q.size() == 0) pass++;
    else $display("FAIL drain: %0d results pending, want 0", q.size());
    q.delete();
  endtask

  task automatic close_out();
    drive(1'b1, 30);
    drive(1'b0, 20);
    check_drain();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sq_in = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sq_in = 1'b1;
    #23;
    total++;
    if ({meas_on, meas_off, meas_valid, meas_err, timeout, busy} === 12'b0) pass++;
    else $display("FAIL reset_outputs: got %b want 0", {meas_on, meas_off, meas_valid, meas_err, timeout, busy});
    sq_in = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    do_reset();
    drive(1'b0, 5);
    period(30, 50);
    sq_in = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (meas_valid === (i == 3)) pass++;
      else $display("FAIL latency_cycle%0d: valid=%0b want %0b", i, meas_valid, i == 3);
    end
    drive(1'b1, 27);
    drive(1'b0, 20);
    check_drain();
  endtask

  task automatic test_basic();
    do_reset();
    drive(1'b0, 5);
    drive(1'b1, 10);
    total++; if (busy === 1'b1) pass++; else $display("FAIL busy_in_high: got %0b want 1", busy);
    drive(1'b1, 20);
    drive(1'b0, 50);
    q.push_back(model(30, 50));
    for (int i = 0; i < 3; i++) period(30, 50);
    close_out();
  endtask

  task automatic test_boundaries();
    do_reset();
    drive(1'b0, 5);
    period(150, 10);
    period(14, 15);
    period(4, 15);
    period(170, 20);
    period(30, 3);
    close_out();
  endtask

  task automatic test_timeout();
    do_reset();
    to_cnt = 0;
    drive(1'b0, 5);
    drive(1'b1, 320);
    drive(1'b0, 20);
    total++; if (to_cnt == 1) pass++; else $display("FAIL timeout_count: got %0d want 1", to_cnt);
    total++; if (busy === 1'b0) pass++; else $display("FAIL busy_after_timeout: got %0b want 0", busy);
    check_drain();
    period(30, 50);
    close_out();
    total++; if (to_cnt == 1) pass++; else $display("FAIL timeout_after_restart: got %0d want 1", to_cnt);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 5);
    period(30, 50);
    drive(1'b1, 30);
    drive(1'b0, 20);
    total++; if (meas_on === 4'd3) pass++; else $display("FAIL pre_reset_on: got %0d want 3", meas_on);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({meas_on, meas_off, meas_valid, meas_err, timeout, busy} === 12'b0) pass++;
    else $display("FAIL async_reset: got %b want 0", {meas_on, meas_off, meas_valid, meas_err, timeout, busy});
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b0, 20);
    check_drain();
    period(30, 50);
    close_out();
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_latency();
    test_basic();
    test_boundaries();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
